door_input_cond: RTL and testbench
==================================

Name: door_input_cond

Overview:
- Input-conditioning stage directly upstream of the door FSM (tt_um_Rescobar226 top).
- Takes raw presence sensor and open/closed limit switches from the pads, synchronises and debounces them, and generates the hold-open expiry signal SE.
- Delivers clean sen, se, la and lc levels that map 1:1 onto the FSM inputs Sen, SE, LA and LC.
- Flags an impossible limit-switch combination.

Parameters:
- DEB_CYCLES, 4, consecutive enabled cycles a synchronised input must differ from its debounced value before the value flips (>=1).
- HOLD_CYCLES, 16, enabled cycles the door must sit fully open with no presence before se asserts (>=1).
- DEB_W, $clog2(DEB_CYCLES+1), debounce counter width (derived).
- HOLD_W, $clog2(HOLD_CYCLES+1), hold counter width (derived).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, synchronous, active-high.
- ena  input  1  clock enable. When low, every register holds.
- sen_raw  input  1  raw presence sensor, asynchronous.
- la_raw  input  1  raw "fully open" limit switch, asynchronous.
- lc_raw  input  1  raw "fully closed" limit switch, asynchronous.
- sen  output  1  debounced presence.
- la  output  1  debounced fully-open.
- lc  output  1  debounced fully-closed.
- se  output  1  hold-open time expired (level), drives FSM SE.
- fault  output  1  sticky: la and lc debounced high simultaneously.

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high, and overrides ena.
- Reset values: all sync flops 0, debounced outputs 0, all counters 0, hold FSM in IDLE, se=0, fault=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Synchroniser: each raw input passes through a 2-flop chain, s1 then s2.
- Debounce, per bit:
  - If s2 == out, cnt <= 0.
  - Else if cnt == DEB_CYCLES-1, out <= s2 and cnt <= 0.
  - Else cnt++.
  - Any bounce back to equality restarts the count.
- Debounce latency: a raw change stable before edge k is visible on the output after edge k+1+DEB_CYCLES (6 cycles at default).
- Hold FSM, states IDLE/WAIT/EXPIRED, evaluated on the debounced signals:
  - IDLE -> WAIT when la & ~sen & ~lc & ~fault; hcnt <= 0.
  - WAIT -> IDLE if sen | ~la | fault.
  - WAIT -> EXPIRED when hcnt == HOLD_CYCLES-1; otherwise hcnt++.
  - EXPIRED -> IDLE if sen | ~la | fault.
- se <= (next state == EXPIRED). se therefore rises exactly HOLD_CYCLES+1 cycles after la rises, given sen stays low.
- se drops one cycle after sen rises or la falls.
- Presence during WAIT restarts the full hold period on the next IDLE->WAIT entry.
- Fault:
  - fault <= fault | (la & lc), sticky until rst.
  - While fault=1, the FSM is forced to IDLE and se=0. sen, la and lc still track their inputs.
- Simultaneous events: in the same cycle, sen rise beats hold expiry; the FSM goes to IDLE, not EXPIRED.
- ena=0 freezes sync flops, counters, outputs and FSM; they resume unchanged when ena returns.
- Reset mid-operation: next cycle, all state is at reset values, including the fault clear.
- Counters never wrap: the debounce counter is bounded by DEB_CYCLES-1 and hcnt by HOLD_CYCLES-1.

Decomposition:
- Package door_pkg:
  - hold FSM state encoding localparams: IDLE=2'd0, WAIT=2'd1, EXPIRED=2'd2; value 3 is illegal and decodes to IDLE.
  - Default DEB_CYCLES and HOLD_CYCLES constants shared with the top.
- Sub-module debounce_bit: synchroniser plus debounce counter, one bit, parameter DEB_CYCLES. Instantiated 3 times.
- Hold FSM and fault logic stay in door_input_cond.

Test Plan:
- Reset: assert rst 2 cycles with all raw inputs high -> all outputs 0 during rst. Then sen, la and lc go to 1 exactly 6 cycles after rst release (DEB_CYCLES=4).
- Bounce: sen_raw toggles 1,0,1 on consecutive cycles, then holds 1 -> sen stays 0 until 6 cycles after the last edge, then goes to 1 with no glitch.
- Hold expiry: la_raw=1, sen_raw=0, lc_raw=0 -> la rises at cycle T, se rises at T+17 (HOLD_CYCLES=16) and stays high.
- Presence restart: as in the hold-expiry case, but pulse sen_raw for 8 cycles at T+10 -> se stays 0. se rises 17 cycles after the debounced sen falls.
- Fault: drive la_raw=lc_raw=1 -> fault=1 seven cycles after la and lc are both high, and se=0. Releasing lc_raw keeps fault=1 until rst.
- Enable: in the hold-expiry case, drop ena for 5 cycles during WAIT -> se is delayed by exactly 5 cycles (T+22).

Source files
------------

// File: rtl/door_pkg.sv
// Shared constants for the door input-conditioning block: hold FSM state
// encoding and the default debounce / hold-open timing.
package door_pkg;

  // Hold FSM states; the unused code 3 is treated as IDLE by the decoder.
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] EXPIRED = 2'd2;

  // Default timing shared with the top level.
  localparam int DEB_CYCLES_DEF  = 4;
  localparam int HOLD_CYCLES_DEF = 16;

endpackage

// File: rtl/debounce_bit.sv
// One-bit input conditioner: two-flop synchroniser followed by a debounce
// counter. The output flips only after the synchronised value has differed
// from it for DEB_CYCLES consecutive enabled cycles.
module debounce_bit #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic raw,
  output logic out
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  logic             s1;
  logic             s2;
  logic [DEB_W-1:0] cnt;

  // Synchronise the raw pad level, then count consecutive disagreements.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      out <= 1'b0;
      cnt <= '0;
    end else if (ena) begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == out) begin
        cnt <= '0;
      end else if (cnt == DEB_W'(DEB_CYCLES - 1)) begin
        out <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + DEB_W'(1);
      end
    end
  end

endmodule

// File: rtl/door_input_cond.sv
// Input conditioning ahead of the door FSM: debounces the presence sensor
// and both limit switches, times the hold-open period to produce se, and
// latches a sticky fault when both limit switches read active together.
module door_input_cond
  import door_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic sen_raw,
  input  logic la_raw,
  input  logic lc_raw,
  output logic sen,
  output logic la,
  output logic lc,
  output logic se,
  output logic fault
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [HOLD_W-1:0] hcnt;
  logic [HOLD_W-1:0] hcnt_nxt;
  logic              open_clear;
  logic              abort;

  debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sen (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .raw (sen_raw),
    .out (sen)
  );

  debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb_la (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .raw (la_raw),
    .out (la)
  );

  debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lc (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .raw (lc_raw),
    .out (lc)
  );

  // Door fully open, nobody present, switches consistent: start timing.
  assign open_clear = la & ~sen & ~lc & ~fault;
  // Presence, door leaving open, or a fault cancels timing; presence is
  // checked ahead of expiry so it wins a same-cycle tie.
  assign abort      = sen | ~la | fault;

  // Next-state and hold counter update for the hold-open timer.
  always_comb begin
    state_nxt = IDLE;
    hcnt_nxt  = hcnt;
    case (state)
      WAIT: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (hcnt == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_nxt = EXPIRED;
        end else begin
          state_nxt = WAIT;
          hcnt_nxt  = hcnt + HOLD_W'(1);
        end
      end
      EXPIRED: begin
        state_nxt = abort ? IDLE : EXPIRED;
      end
      default: begin
        if (open_clear) begin
          state_nxt = WAIT;
          hcnt_nxt  = '0;
        end
      end
    endcase
  end

  // Register FSM state, hold count, the se level and the sticky fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hcnt  <= '0;
      se    <= 1'b0;
      fault <= 1'b0;
    end else if (ena) begin
      state <= state_nxt;
      hcnt  <= hcnt_nxt;
      se    <= (state_nxt == EXPIRED);
      fault <= fault | (la & lc);
    end
  end

endmodule

// File: tb/tb_door_input_cond.sv
// Bench for door_input_cond: directed scenarios with literal latency checks,
// then randomized pad activity, with a behavioural model compared every cycle.
module tb_door_input_cond;

  localparam int DEB  = 4;
  localparam int HOLD = 16;

  logic clk = 1'b0;
  logic rst, ena, sen_raw, la_raw, lc_raw;
  logic sen, la, lc, se, fault;

  int   vectors     = 0;
  int   miscompares = 0;
  logic checking    = 1'b0;

  door_input_cond #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .sen_raw (sen_raw),
    .la_raw  (la_raw),
    .lc_raw  (lc_raw),
    .sen     (sen),
    .la      (la),
    .lc      (lc),
    .se      (se),
    .fault   (fault)
  );

  always #5 clk = ~clk;

  // Behavioural model. Index 0 = sen, 1 = la, 2 = lc.
  // m_hist holds the last DEB synchronised samples seen by the debouncer;
  // the clean level flips once all of them disagree with it.
  // m_t counts enabled cycles since timing started (-1 = not timing);
  // se is high once that count reaches HOLD.
  logic           m_s1 [3];
  logic           m_s2 [3];
  logic           m_out[3];
  logic [DEB-1:0] m_hist[3];
  logic           m_fault, m_se;
  int             m_t;
  logic           o_sen, o_la, o_lc, o_f;

  function automatic logic raw_of(input int b);
    case (b)
      0:       return sen_raw;
      1:       return la_raw;
      default: return lc_raw;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 3; b++) begin
        m_s1[b] = 1'b0; m_s2[b] = 1'b0; m_out[b] = 1'b0; m_hist[b] = '0;
      end
      m_fault = 1'b0;
      m_se    = 1'b0;
      m_t     = -1;
    end else if (ena) begin
      o_sen = m_out[0]; o_la = m_out[1]; o_lc = m_out[2]; o_f = m_fault;
      for (int b = 0; b < 3; b++) begin
        m_hist[b] = {m_hist[b][DEB-2:0], m_s2[b]};
        if (m_hist[b] == {DEB{~m_out[b]}}) m_out[b] = ~m_out[b];
        m_s2[b] = m_s1[b];
        m_s1[b] = raw_of(b);
      end
      if (m_t < 0) begin
        if (o_la && !o_sen && !o_lc && !o_f) m_t = 0;
      end else if (o_sen || !o_la || o_f) begin
        m_t = -1;
      end else if (m_t < HOLD) begin
        m_t = m_t + 1;
      end
      m_se    = (m_t >= HOLD);
      m_fault = o_f | (o_la & o_lc);
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (checking) begin
      vectors++;
      if ({sen, la, lc, se, fault} !== {m_out[0], m_out[1], m_out[2], m_se, m_fault}) begin
        miscompares++;
        $display("FAIL cycle_compare at %0t: dut sen,la,lc,se,fault=%b model=%b", $time,
                 {sen, la, lc, se, fault}, {m_out[0], m_out[1], m_out[2], m_se, m_fault});
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return sen;
      1:       return la;
      2:       return lc;
      3:       return se;
      default: return fault;
    endcase
  endfunction

  // Count rising edges until the selected output equals val; -1 on timeout.
  task automatic wait_for(input int which, input logic val, input int maxn, output int n);
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      n++;
      if (sig(which) === val) return;
      if (n >= maxn) begin
        n = -1;
        return;
      end
    end
  endtask

  task automatic do_reset(input logic s, input logic a, input logic c);
    @(negedge clk);
    rst = 1'b1; ena = 1'b1; sen_raw = s; la_raw = a; lc_raw = c;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int n, n2;
    rst = 1'b1; ena = 1'b1; sen_raw = 1'b1; la_raw = 1'b1; lc_raw = 1'b1;

    // Reset with all pads high: outputs stay low, then follow after 6 edges.
    @(posedge clk); #1;
    checking = 1'b1;
    chk("reset_outputs_c1", {sen, la, lc, se, fault}, 0);
    @(posedge clk); #1;
    chk("reset_outputs_c2", {sen, la, lc, se, fault}, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_for(0, 1'b1, 20, n);
    chk("reset_release_latency", n, 6);
    chk("reset_release_la_lc", {la, lc}, 2'b11);

    // Bounce on sen_raw: 1,0,1 then hold.
    do_reset(1'b0, 1'b0, 1'b0);
    sen_raw = 1'b1; @(negedge clk);
    sen_raw = 1'b0; @(negedge clk);
    sen_raw = 1'b1;
    wait_for(0, 1'b1, 20, n);
    chk("bounce_latency", n, 6);
    repeat (4) @(posedge clk);
    #1 chk("bounce_stays_high", sen, 1);

    // Hold expiry, then se drops one cycle after la falls.
    do_reset(1'b0, 1'b0, 1'b0);
    la_raw = 1'b1;
    wait_for(1, 1'b1, 20, n);
    chk("la_latency", n, 6);
    wait_for(3, 1'b1, 40, n);
    chk("hold_expiry", n, HOLD + 1);
    repeat (5) @(posedge clk);
    #1 chk("se_stays_high", se, 1);
    @(negedge clk);
    la_raw = 1'b0;
    wait_for(1, 1'b0, 20, n);
    wait_for(3, 1'b0, 5, n);
    chk("se_drop_after_la", n, 1);

    // Presence restart during WAIT.
    do_reset(1'b0, 1'b0, 1'b0);
    la_raw = 1'b1;
    wait_for(1, 1'b1, 20, n);
    repeat (9) @(posedge clk);
    #1 sen_raw = 1'b1;
    repeat (8) @(posedge clk);
    #1 sen_raw = 1'b0;
    wait_for(0, 1'b0, 20, n);
    chk("restart_se_low_at_sen_fall", se, 0);
    wait_for(3, 1'b1, 40, n);
    chk("restart_hold", n, HOLD + 1);

    // Enable dropped for 5 cycles during WAIT.
    do_reset(1'b0, 1'b0, 1'b0);
    la_raw = 1'b1;
    wait_for(1, 1'b1, 20, n);
    repeat (3) @(posedge clk);
    #1 ena = 1'b0;
    repeat (5) @(posedge clk);
    #1 ena = 1'b1;
    wait_for(3, 1'b1, 40, n2);
    chk("enable_delay", (n2 < 0) ? -1 : 3 + 5 + n2, HOLD + 6);

    // Fault: both limits, sticky until reset.
    do_reset(1'b0, 1'b0, 1'b0);
    la_raw = 1'b1; lc_raw = 1'b1;
    wait_for(4, 1'b1, 30, n);
    chk("fault_latency", n, 7);
    chk("fault_se_low", se, 0);
    @(negedge clk);
    lc_raw = 1'b0;
    repeat (30) @(posedge clk);
    #1 chk("fault_sticky", fault, 1);
    chk("fault_blocks_se", se, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("fault_cleared_by_rst", {sen, la, lc, se, fault}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized activity: held levels with glitches, enable gaps, resets.
    for (int seg = 0; seg < 300; seg++) begin
      int len;
      logic s, a, c;
      len = $urandom_range(1, 30);
      s   = ($urandom_range(0, 99) < 30);
      a   = ($urandom_range(0, 99) < 70);
      c   = ($urandom_range(0, 99) < 8);
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        rst     = ($urandom_range(0, 199) == 0);
        ena     = ($urandom_range(0, 99) < 90);
        sen_raw = ($urandom_range(0, 99) < 5) ? ~s : s;
        la_raw  = ($urandom_range(0, 99) < 5) ? ~a : a;
        lc_raw  = c;
      end
    end

    @(negedge clk);
    rst = 1'b0; ena = 1'b1;
    repeat (3) @(negedge clk);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
